// File: rtl/cm_merge.sv
// Two-into-one merge for the Send/Ack pipeline: round-robin arbitration between
// upstream channels a and b, one-token holding register toward downstream.
module cm_merge #(
  parameter int DW = 8
) (
  input  logic          CP,
  input  logic          MR,
  input  logic          CM_Send_in_a,
  input  logic [DW-1:0] CM_Data_in_a,
  output logic          CM_Ack_out_a,
  input  logic          CM_Send_in_b,
  input  logic [DW-1:0] CM_Data_in_b,
  output logic          CM_Ack_out_b,
  output logic          CM_Send_out,
  output logic [DW-1:0] CM_Data_out,
  input  logic          CM_Ack_in,
  output logic          CM_Sel_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic          ptr_reg, ptr_next;        // 0 = a preferred on a tie, 1 = b
  logic          sel_reg, sel_next;
  logic [DW-1:0] data_reg, data_next;
  logic          ack_a_reg, ack_a_next;
  logic          ack_b_reg, ack_b_next;
  logic          send_reg, send_next;
  logic          in_done_reg, in_done_next;
  logic          out_done_reg, out_done_next;

  logic          grant_b;
  logic          granted_send;

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state_reg    <= IDLE;
      ptr_reg      <= 1'b0;
      sel_reg      <= 1'b0;
      data_reg     <= '0;
      ack_a_reg    <= 1'b0;
      ack_b_reg    <= 1'b0;
      send_reg     <= 1'b0;
      in_done_reg  <= 1'b0;
      out_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      sel_reg      <= sel_next;
      data_reg     <= data_next;
      ack_a_reg    <= ack_a_next;
      ack_b_reg    <= ack_b_next;
      send_reg     <= send_next;
      in_done_reg  <= in_done_next;
      out_done_reg <= out_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    sel_next      = sel_reg;
    data_next     = data_reg;
    ack_a_next    = ack_a_reg;
    ack_b_next    = ack_b_reg;
    send_next     = send_reg;
    in_done_next  = in_done_reg;
    out_done_next = out_done_reg;
    grant_b       = 1'b0;
    granted_send  = sel_reg ? CM_Send_in_b : CM_Send_in_a;

    case (state_reg)
      IDLE: begin
        // Downstream must have fully released before a new token is offered.
        if (!CM_Ack_in && (CM_Send_in_a || CM_Send_in_b)) begin
          grant_b       = CM_Send_in_b && (!CM_Send_in_a || ptr_reg);
          ptr_next      = !grant_b;
          sel_next      = grant_b;
          data_next     = grant_b ? CM_Data_in_b : CM_Data_in_a;
          ack_a_next    = !grant_b;
          ack_b_next    = grant_b;
          send_next     = 1'b1;
          in_done_next  = 1'b0;
          out_done_next = 1'b0;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (in_done_reg && out_done_reg) begin
          in_done_next  = 1'b0;
          out_done_next = 1'b0;
          state_next    = IDLE;
        end else begin
          if (!in_done_reg && !granted_send) begin
            ack_a_next   = 1'b0;
            ack_b_next   = 1'b0;
            in_done_next = 1'b1;
          end
          if (send_reg && CM_Ack_in) begin
            send_next = 1'b0;
          end
          // send_reg only falls after Ack_in was seen high, so a low Ack_in
          // while send_reg is low closes the downstream half.
          if (!send_reg && !out_done_reg && !CM_Ack_in) begin
            out_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign CM_Ack_out_a = ack_a_reg;
  assign CM_Ack_out_b = ack_b_reg;
  assign CM_Send_out  = send_reg;
  assign CM_Data_out  = data_reg;
  assign CM_Sel_out   = sel_reg;

endmodule

// File: tb/tb_cm_merge.sv
// Directed bench for cm_merge: handshake agents on both sides, scoreboard of
// expected {sel, data} tokens checked as each token is accepted downstream.
`timescale 1ns/1ps
module tb_cm_merge;
  localparam int DW = 8;

  logic          CP = 1'b0;
  logic          MR;
  logic          ua_send, ub_send, raw_a;
  logic [DW-1:0] ua_data, ub_data, raw_data;
  logic          ds_ack, force_ack;

  logic          CM_Send_in_a, CM_Send_in_b, CM_Ack_out_a, CM_Ack_out_b;
  logic [DW-1:0] CM_Data_in_a, CM_Data_in_b, CM_Data_out;
  logic          CM_Send_out, CM_Ack_in, CM_Sel_out;

  int            errors = 0;
  int            checks = 0;
  int            ds_delay = 0;
  logic [DW:0]   sb[$];
  logic [DW-1:0] qa[$], qb[$];
  logic          saw;

  assign CM_Send_in_a = ua_send | raw_a;
  assign CM_Data_in_a = raw_a ? raw_data : ua_data;
  assign CM_Send_in_b = ub_send;
  assign CM_Data_in_b = ub_data;
  assign CM_Ack_in    = ds_ack | force_ack;

  cm_merge #(.DW(DW)) dut (
    .CP(CP), .MR(MR),
    .CM_Send_in_a(CM_Send_in_a), .CM_Data_in_a(CM_Data_in_a), .CM_Ack_out_a(CM_Ack_out_a),
    .CM_Send_in_b(CM_Send_in_b), .CM_Data_in_b(CM_Data_in_b), .CM_Ack_out_b(CM_Ack_out_b),
    .CM_Send_out(CM_Send_out), .CM_Data_out(CM_Data_out),
    .CM_Ack_in(CM_Ack_in), .CM_Sel_out(CM_Sel_out)
  );

  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic up_a();
    forever begin
      @(negedge CP);
      if (!MR) ua_send = 1'b0;
      else if (!ua_send && !CM_Ack_out_a && qa.size() > 0) begin
        ua_data = qa[0];
        ua_send = 1'b1;
      end else if (ua_send && CM_Ack_out_a) begin
        ua_send = 1'b0;
        void'(qa.pop_front());
      end
    end
  endtask

  task automatic up_b();
    forever begin
      @(negedge CP);
      if (!MR) ub_send = 1'b0;
      else if (!ub_send && !CM_Ack_out_b && qb.size() > 0) begin
        ub_data = qb[0];
        ub_send = 1'b1;
      end else if (ub_send && CM_Ack_out_b) begin
        ub_send = 1'b0;
        void'(qb.pop_front());
      end
    end
  endtask

  task automatic down();
    int cnt = 0;
    logic [DW:0] exp;
    forever begin
      @(negedge CP);
      if (!MR) begin
        ds_ack = 1'b0;
        cnt = 0;
      end else if (CM_Send_out && !ds_ack) begin
        if (cnt >= ds_delay) begin
          cnt = 0;
          ds_ack = 1'b1;
          chk("token_expected", 32'(sb.size() == 0), 32'd0);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("tok_data", 32'(CM_Data_out), 32'(exp[DW-1:0]));
            chk("tok_sel", 32'(CM_Sel_out), 32'(exp[DW]));
            $display("token data=%02h sel=%0d", CM_Data_out, CM_Sel_out);
          end
        end else cnt++;
      end else if (!CM_Send_out && ds_ack) begin
        ds_ack = 1'b0;
      end
    end
  endtask

  task automatic wait_send(input int budget);
    int n = 0;
    while (!CM_Send_out && n < budget) begin
      tick();
      n++;
    end
    chk("send_timeout", 32'(CM_Send_out), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = sb.size() == 0 && qa.size() == 0 && qb.size() == 0 && !CM_Send_out &&
             !CM_Ack_out_a && !CM_Ack_out_b && !CM_Ack_in && !CM_Send_in_a && !CM_Send_in_b;
    end
    chk("drain", 32'(done), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    MR = 1'b1;
    ua_send = 0; ub_send = 0; raw_a = 0;
    ua_data = '0; ub_data = '0; raw_data = '0;
    ds_ack = 0; force_ack = 0;
    #2 MR = 1'b0;
    fork
      up_a();
      up_b();
      down();
    join_none

    // Reset state
    tick();
    tick();
    chk("rst_ack_a", 32'(CM_Ack_out_a), 32'd0);
    chk("rst_ack_b", 32'(CM_Ack_out_b), 32'd0);
    chk("rst_send", 32'(CM_Send_out), 32'd0);
    chk("rst_sel", 32'(CM_Sel_out), 32'd0);
    chk("rst_data", 32'(CM_Data_out), 32'd0);
    MR = 1'b1;
    tick();

    // Single token on a, downstream acks one cycle later
    ds_delay = 1;
    qa.push_back(8'h3C);
    sb.push_back({1'b0, 8'h3C});
    tick();
    chk("t1_ack_a", 32'(CM_Ack_out_a), 32'd1);
    chk("t1_send", 32'(CM_Send_out), 32'd1);
    chk("t1_data", 32'(CM_Data_out), 32'h3C);
    chk("t1_sel", 32'(CM_Sel_out), 32'd0);
    wait_done(50);

    // Both channels requesting continuously after a fresh reset
    MR = 1'b0;
    tick();
    MR = 1'b1;
    ds_delay = 0;
    for (int i = 0; i < 2; i++) begin
      qa.push_back(8'hA1);
      qb.push_back(8'hB2);
      sb.push_back({1'b0, 8'hA1});
      sb.push_back({1'b1, 8'hB2});
    end
    wait_done(200);

    // Downstream stall of 10 cycles with b pending
    ds_delay = 10;
    qa.push_back(8'h55);
    qb.push_back(8'h66);
    sb.push_back({1'b0, 8'h55});
    sb.push_back({1'b1, 8'h66});
    wait_send(20);
    for (int i = 0; i < 10; i++) begin
      chk("t3_send_held", 32'(CM_Send_out), 32'd1);
      chk("t3_data_held", 32'(CM_Data_out), 32'h55);
      chk("t3_b_pending", 32'(CM_Ack_out_b), 32'd0);
      if (i < 9) tick();
    end
    chk("t3_ack_a_done", 32'(CM_Ack_out_a), 32'd0);
    wait_done(200);

    // Ack_in held high blocks grants
    ds_delay = 0;
    force_ack = 1'b1;
    qb.push_back(8'h77);
    sb.push_back({1'b1, 8'h77});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_grant_send", 32'(CM_Send_out), 32'd0);
      chk("t4_no_grant_ack", 32'(CM_Ack_out_b), 32'd0);
    end
    force_ack = 1'b0;
    tick();
    chk("t4_grant_send", 32'(CM_Send_out), 32'd1);
    chk("t4_grant_ack_b", 32'(CM_Ack_out_b), 32'd1);
    chk("t4_data", 32'(CM_Data_out), 32'h77);
    chk("t4_sel", 32'(CM_Sel_out), 32'd1);
    wait_done(50);

    // Asynchronous reset while BUSY on b
    ds_delay = 20;
    qb.push_back(8'h88);
    sb.push_back({1'b1, 8'h88});
    wait_send(20);
    chk("t5_busy_ack_b", 32'(CM_Ack_out_b), 32'd1);
    MR = 1'b0;
    #1;
    chk("t5_async_send", 32'(CM_Send_out), 32'd0);
    chk("t5_async_ack_b", 32'(CM_Ack_out_b), 32'd0);
    chk("t5_async_ack_a", 32'(CM_Ack_out_a), 32'd0);
    chk("t5_async_sel", 32'(CM_Sel_out), 32'd0);
    chk("t5_async_data", 32'(CM_Data_out), 32'd0);
    qa.delete();
    qb.delete();
    sb.delete();
    ds_delay = 0;
    tick();
    tick();
    MR = 1'b1;
    qa.push_back(8'h11);
    qb.push_back(8'h22);
    sb.push_back({1'b0, 8'h11});
    sb.push_back({1'b1, 8'h22});
    wait_send(20);
    chk("t5_first_a", 32'(CM_Ack_out_a), 32'd1);
    chk("t5_first_data", 32'(CM_Data_out), 32'h11);
    wait_done(100);

    // One-cycle pulse on a while serving b is ignored
    ds_delay = 5;
    qb.push_back(8'h99);
    sb.push_back({1'b1, 8'h99});
    wait_send(20);
    chk("t6_sel_b", 32'(CM_Sel_out), 32'd1);
    raw_data = 8'hEE;
    raw_a = 1'b1;
    saw = CM_Ack_out_a;
    tick();
    raw_a = 1'b0;
    for (int i = 0; i < 25; i++) begin
      saw = saw | CM_Ack_out_a;
      tick();
    end
    chk("t6_no_ack_a", 32'(saw), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw = saw | CM_Send_out;
      tick();
    end
    chk("t6_stays_idle", 32'(saw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
